// File: rtl/program_loader.sv
// Boot loader: packs a little-endian UART byte stream (word count, then words)
// into sequential memory writes, then returns a single acknowledge byte.
module program_loader #(
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_WORDS = 12001,
    parameter logic [7:0]  ACK_OK    = 8'hAA,
    parameter logic [7:0]  ACK_ERR   = 8'h55
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_di,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {HDR, LOAD, ACK, FIN} state_e;

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);
    localparam logic [31:0] BASE  = 32'(BASE_ADDR);

    state_e      state_q, state_d;
    logic [1:0]  bi_q, bi_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] n_q, n_d;
    logic [31:0] wc_q, wc_d;
    logic        mem_en_q, mem_en_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_di_q, mem_di_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        take;
    logic        last_byte;
    logic [31:0] word;

    // The completed group uses the live byte, so no extra cycle is spent repacking.
    assign take      = rx_valid && (state_q == HDR || state_q == LOAD);
    assign last_byte = take && (bi_q == 2'd3);
    assign word      = {rx_data, acc_q[23:0]};

    always_comb begin
        state_d    = state_q;
        bi_d       = bi_q;
        acc_d      = acc_q;
        n_d        = n_q;
        wc_d       = wc_q;
        mem_en_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_di_d   = mem_di_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        done_d     = done_q;
        err_d      = err_q;

        if (take) begin
            bi_d = bi_q + 2'd1;
            acc_d[{bi_q, 3'b000} +: 8] = rx_data;
        end

        case (state_q)
            HDR: begin
                if (last_byte) begin
                    n_d = word;
                    if (word > MAX_W) begin
                        err_d      = 1'b1;
                        tx_data_d  = ACK_ERR;
                        tx_valid_d = 1'b1;
                        state_d    = ACK;
                    end else if (word == 32'd0) begin
                        tx_data_d  = ACK_OK;
                        tx_valid_d = 1'b1;
                        state_d    = ACK;
                    end else begin
                        wc_d    = 32'd0;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (last_byte) begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = BASE + wc_q;
                    mem_di_d   = word;
                    wc_d       = wc_q + 32'd1;
                    if (wc_q + 32'd1 == n_q) begin
                        tx_data_d = ACK_OK;
                        state_d   = ACK;
                    end
                end
            end
            ACK: begin
                // After a load, tx_valid rises one cycle behind the final write pulse.
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                end else if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = FIN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= HDR;
            bi_q       <= 2'd0;
            acc_q      <= 32'd0;
            n_q        <= 32'd0;
            wc_q       <= 32'd0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= 32'd0;
            mem_di_q   <= 32'd0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bi_q       <= bi_d;
            acc_q      <= acc_d;
            n_q        <= n_d;
            wc_q       <= wc_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
            mem_di_q   <= mem_di_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign mem_en   = mem_en_q;
    assign mem_we   = mem_en_q;
    assign mem_addr = mem_addr_q;
    assign mem_di   = mem_di_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign done     = done_q;
    assign err      = err_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a write scoreboard per instance (base 0 and
// base 100) checks every memory pulse; the ack/done/err sequence is checked inline.
module tb_program_loader;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        tx_ready = 1'b0;

    logic        tx_valid, mem_en, mem_we, done, err;
    logic [7:0]  tx_data;
    logic [31:0] mem_addr, mem_di;

    logic        tx_valid1, mem_en1, mem_we1, done1, err1;
    logic [7:0]  tx_data1;
    logic [31:0] mem_addr1, mem_di1;

    program_loader dut (
        .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
        .done(done), .err(err)
    );

    program_loader #(.BASE_ADDR(100)) dut100 (
        .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid1), .tx_data(tx_data1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_di(mem_di1),
        .done(done1), .err(err1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  widx = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every write pulse must match the oldest pending entry.
    always @(negedge clk) begin
        if (rstn && (mem_we || mem_en)) begin
            if (q0.size() == 0) begin
                chk("unexpected_write", {mem_addr, mem_di}, 80'd0);
            end else begin
                wr_t e;
                e = q0.pop_front();
                chk("write", {mem_en, mem_we, mem_addr, mem_di, 16'(cyc)},
                    {1'b1, 1'b1, e.addr, e.data, 16'(e.cyc)});
            end
        end
        if (rstn && (mem_we1 || mem_en1)) begin
            if (q1.size() == 0) begin
                chk("unexpected_write_base100", {mem_addr1, mem_di1}, 80'd0);
            end else begin
                wr_t e;
                e = q1.pop_front();
                chk("write_base100", {mem_en1, mem_we1, mem_addr1, mem_di1, 16'(cyc)},
                    {1'b1, 1'b1, e.addr, e.data, 16'(e.cyc)});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one little-endian word; data words push their expected write.
    task automatic send_word(input logic [31:0] w, input int gap, input bit is_data);
        for (int k = 0; k < 4; k++) begin
            rx_valid = 1'b1;
            rx_data  = w[8*k +: 8];
            if (is_data && k == 3) begin
                wr_t e;
                e.addr = 32'(widx);
                e.data = w;
                e.cyc  = cyc + 1;
                q0.push_back(e);
                e.addr = 32'(widx + 100);
                q1.push_back(e);
                widx++;
            end
            tick();
            rx_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        widx = 0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic handshake(input string tag);
        chk({tag, "_done_before"}, 80'(done), 80'd0);
        tx_ready = 1'b1;
        tick();
        chk({tag, "_done_txv_after"}, {done, tx_valid}, {1'b1, 1'b0});
        tx_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("reset_outputs", {mem_en, mem_we, mem_addr, mem_di, tx_valid, tx_data, done, err}, 80'd0);
        do_reset();

        // Two words back-to-back
        send_word(32'd2, 0, 1'b0);
        send_word(32'h12345678, 0, 1'b1);
        send_word(32'hDEADBEEF, 0, 1'b1);
        chk("t1_txv_in_pulse_cycle", 80'(tx_valid), 80'd0);
        tick();
        chk("t1_ack", {tx_valid, tx_data, err}, {1'b1, 8'hAA, 1'b0});
        handshake("t1");
        chk("t1_queue_empty", 80'(q0.size() + q1.size()), 80'd0);

        // N = 0
        do_reset();
        send_word(32'd0, 0, 1'b0);
        chk("t2_ack", {tx_valid, tx_data, err}, {1'b1, 8'hAA, 1'b0});
        handshake("t2");
        chk("t2_err", 80'(err), 80'd0);

        // N = MAX_WORDS + 1 rejected
        do_reset();
        send_word(32'h00002EE2, 0, 1'b0);
        chk("t3_ack_err", {tx_valid, tx_data, err}, {1'b1, 8'h55, 1'b1});
        handshake("t3");
        chk("t3_err_sticky", 80'(err), 80'd1);

        // N = 1, spaced bytes, slow transmitter
        do_reset();
        send_word(32'd1, 5, 1'b0);
        send_word(32'hCAFEF00D, 5, 1'b1);
        for (int i = 0; i < 10; i++)
            chk("t4_hold", {tx_valid, tx_data, done}, {1'b1, 8'hAA, 1'b0});
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_hold_cyc", {tx_valid, tx_data, done}, {1'b1, 8'hAA, 1'b0});
        end
        handshake("t4");
        chk("t4_queue_empty", 80'(q0.size() + q1.size()), 80'd0);

        // Reset mid-load after 6 of 8 data bytes
        do_reset();
        send_word(32'd2, 0, 1'b0);
        send_word(32'h11223344, 0, 1'b1);
        rx_valid = 1'b1; rx_data = 8'h55; tick();
        rx_data = 8'h66; tick();
        rx_valid = 1'b0;
        chk("t5_pre_reset_addr_di", {mem_addr, mem_di}, {32'd0, 32'h11223344});
        rstn = 1'b0;
        #1;
        chk("t5_async_reset", {mem_en, mem_we, mem_addr, mem_di, tx_valid, tx_data, done, err}, 80'd0);
        widx = 0;
        tick();
        rstn = 1'b1;
        tick();
        send_word(32'd1, 0, 1'b0);
        send_word(32'hDDCCBBAA, 0, 1'b1);
        tick();
        chk("t5_ack", {tx_valid, tx_data}, {1'b1, 8'hAA});
        handshake("t5");

        // Bytes after done are ignored
        tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_word(32'h01000000 + 32'(i), 0, 1'b0);
            chk("t6_fin", {tx_valid, done, err}, {1'b0, 1'b1, 1'b0});
        end
        tick();
        tick();
        chk("final_queue_empty", 80'(q0.size() + q1.size()), 80'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
